// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the regfile_sb register bank.
//   DATA_W_DEF / ADDR_W_DEF : default register width and address width
//   BUS_MAX_W               : widest packed port bus bus_field() can slice
//   bus_field()             : extract field k of width w from a packed bus
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned BUS_MAX_W  = 256;

    // Field k of a packed bus whose fields are w bits wide, zero-extended.
    function automatic logic [BUS_MAX_W-1:0] bus_field(input logic [BUS_MAX_W-1:0] bus,
                                                       input int unsigned          k,
                                                       input int unsigned          w);
        logic [BUS_MAX_W-1:0] mask;
        mask = (BUS_MAX_W'(1) << w) - BUS_MAX_W'(1);
        return (bus >> (k * w)) & mask;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port of regfile_sb.
//   addr      : register being read
//   mem_data  : stored value of that register
//   mem_busy  : stored pending bit of that register
//   fwd_en    : a write is committing this cycle and may be forwarded
//   wr_addr   : register being written
//   wr_data   : value being written
//   data/busy : resolved read value and pending flag
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_busy,
    input  logic              fwd_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data,
    output logic              busy
);

    always_comb begin
        data = mem_data;
        busy = mem_busy;
        if (ZERO_REG && (addr == '0)) begin
            data = '0;
            busy = 1'b0;
        end else if (BYPASS && fwd_en && (wr_addr == addr)) begin
            // The writeback clears the pending bit on this edge, so report it free now.
            data = wr_data;
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with per-register busy (pending-write) scoreboard.
//   clk, rst            : clock, asynchronous active-high reset
//   rd_addr / rd_data   : N_RD packed read ports (port k at [k*W +: W])
//   rd_busy             : pending flag of each read port's register
//   wr_en/addr/data     : writeback port, clears the pending bit
//   rsv_en / rsv_addr   : reservation port, sets the pending bit
//   busy_vec / busy_cnt : registered pending bits and their count
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned N_RD     = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_RD*ADDR_W-1:0] rd_addr,
    output logic [N_RD*DATA_W-1:0] rd_data,
    output logic [N_RD-1:0]        rd_busy,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rsv_en,
    input  logic [ADDR_W-1:0]      rsv_addr,
    output logic [2**ADDR_W-1:0]   busy_vec,
    output logic [ADDR_W:0]        busy_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              wr_eff, rsv_eff, fwd_en, cnt_inc, cnt_dec;

    assign wr_eff  = wr_en  && !(ZERO_REG && (wr_addr == '0));
    assign rsv_eff = rsv_en && !(ZERO_REG && (rsv_addr == '0));
    // No forwarding while in reset so the read ports show the cleared state.
    assign fwd_en  = wr_eff && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_eff) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Reserve is applied after write so a new producer wins on the same register.
    always_comb begin
        busy_d = busy_q;
        if (wr_eff) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_eff) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // Counter only moves on real 0->1 / 1->0 transitions of a busy bit.
    always_comb begin
        cnt_inc = rsv_eff && !busy_q[rsv_addr];
        cnt_dec = wr_eff && busy_q[wr_addr] && !(rsv_eff && (rsv_addr == wr_addr));
        cnt_d   = cnt_q;
        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_vec = busy_q;
    assign busy_cnt = cnt_q;

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_k;

        assign addr_k = ADDR_W'(bus_field(BUS_MAX_W'(rd_addr), k, ADDR_W));

        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd_port (
            .addr     (addr_k),
            .mem_data (mem_q[addr_k]),
            .mem_busy (busy_q[addr_k]),
            .fwd_en   (fwd_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .data     (rd_data[k*DATA_W +: DATA_W]),
            .busy     (rd_busy[k])
        );
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with an integrated busy-bit scoreboard: the next-generation register bank for the KGPminiRISC datapath. It provides N_RD combinational read ports with optional same-cycle write bypass and a hardwired-zero register option. Per-register pending bits are set when a multi-cycle producer (load, multi-cycle ALU op) issues and cleared on its writeback, so the decode stage can detect RAW hazards. It sits between decode (reads, reservations) and writeback (writes).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- N_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never busy
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  N_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  N_RD*DATA_W  read data, same packing
- rd_busy  out  N_RD  pending flag of each read port's register
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback register
- wr_data  in  DATA_W  writeback value
- rsv_en  in  1  mark rsv_addr pending
- rsv_addr  in  ADDR_W  register to reserve
- busy_vec  out  2**ADDR_W  registered busy bits, bit i = register i
- busy_cnt  out  ADDR_W+1  number of set busy bits

## Operation
- Reset (async, while rst=1): all registers 0, busy_vec 0, busy_cnt 0; rd_data reflects 0 and rd_busy is 0.
- Effective write: wr_en & ~(ZERO_REG & wr_addr==0). On clk: mem[wr_addr] <= wr_data; busy[wr_addr] <= 0.
- Effective reserve: rsv_en & ~(ZERO_REG & rsv_addr==0). On clk: busy[rsv_addr] <= 1.
- Write and reserve to the same address in one cycle: data written AND busy ends 1 (new producer wins).
- Write to a non-busy register is legal; data updates, busy stays 0.
- Reserve of an already-busy register: busy stays 1 and the count is unchanged.
- busy_cnt is maintained as a counter, not a popcount: +1 when an effective reserve sets a 0 bit; -1 when an effective write clears a 1 bit (not re-reserved); net 0 when both happen. It always equals popcount(busy_vec).
- Read port k, address a (combinational):
  - ZERO_REG & a==0: data 0, busy 0.
  - Else if BYPASS & effective write & wr_addr==a: data = wr_data, busy = 0.
  - Else: data = mem[a], busy = busy[a].
- Reservation bypass is not applied: a same-cycle rsv_en does not affect rd_busy until the next cycle.

## Timing
- Read latency 0 (combinational from rd_addr, mem, busy, and the write port when BYPASS=1).
- Writes and reservations are visible on the cycle after the edge that commits them (same cycle for data when BYPASS=1).
- busy_vec and busy_cnt are registered and update on the commit edge.
- rst asserted mid-operation clears everything immediately, independent of clk. An in-flight wr_en or rsv_en on the edge where rst deasserts is ignored only if rst is still high at that edge.

## Structure
- Package regfile_pkg: default DATA_W and ADDR_W constants, and a function to extract port k from a packed address or data bus.
- Sub-module regfile_rd_port: a single read mux with zero-register and bypass logic, instantiated N_RD times via generate.
- Top level holds the storage array, the busy register and the busy_cnt counter.

## Test plan
- Reset: write 0xDEADBEEF to r5, pulse rst -> rd_data(r5)=0, busy_vec=0, busy_cnt=0.
- Zero register: wr_en to r0 with 0x1234 and rsv_en r0 -> r0 reads 0, rd_busy=0, busy_cnt=0. Repeat with ZERO_REG=0 -> r0 reads 0x1234 and is busy.
- Bypass: wr_en r3=0xA5A5A5A5 while port1 reads r3 -> same-cycle rd_data=0xA5A5A5A5, rd_busy=0. Repeat with BYPASS=0 -> old value returned until the next cycle.
- Scoreboard: rsv r7, then rsv r9 -> busy_cnt=2, rd_busy(r7)=1. Write r7 -> busy_cnt=1, r7 not busy.
- Simultaneous events: rsv r4 and wr r4=0x55 in one cycle -> r4=0x55, busy[4]=1, busy_cnt +1. Then rsv r9 with wr r9 while r9 busy -> busy_cnt unchanged.
- Random: N_RD=4, 10k cycles of random wr/rsv/reads against a reference model -> all rd_data, rd_busy and busy_cnt match, and busy_cnt always equals popcount(busy_vec).
